mem_access_sequencer: RTL and testbench
=======================================

Name: mem_access_sequencer

Overview:
Upstream front-end for the two-block data memory. It accepts single load/store requests from the datapath over a valid/ready handshake and splits the address into a bank bit and a word address. It drives the 2-bit memoryena code {bank, write} consumed by the block-enable decoder, waits out the block RAM read latency, and returns read data over a held response handshake.

Parameters:
ADDR_WIDTH, 12, request address width; MSB is the bank select, lower ADDR_WIDTH-1 bits are the word address.
DATA_WIDTH, 32, data word width.
READ_LATENCY, 1, cycles from the edge that samples the address to the edge after which block dout is valid; legal values are 1..4 (elaboration error otherwise).

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous active-low reset.
req_valid  in  1  request present; requester holds all req_* stable until accepted.
req_ready  out  1  request accepted on an edge where req_valid&&req_ready.
req_write  in  1  1 = store, 0 = load.
req_addr  in  ADDR_WIDTH  bank bit + word address.
req_wdata  in  DATA_WIDTH  store data.
resp_valid  out  1  load data available; held until accepted.
resp_ready  in  1  consumer accepts the response.
resp_rdata  out  DATA_WIDTH  load data.
memoryena  out  2  {bank, write} to the block-enable decoder.
mem_addr  out  ADDR_WIDTH-1  word address to both blocks.
mem_din  out  DATA_WIDTH  write data to both blocks.
block1_dout  in  DATA_WIDTH  block 1 read data.
block2_dout  in  DATA_WIDTH  block 2 read data.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; memoryena=2'b00, mem_addr=0, mem_din=0, resp_valid=0, resp_rdata=0, busy=0, internal counter=0. req_ready is 0 while rst_n=0.
- A reset mid-operation aborts the operation. memoryena returns to 00 on that edge, any pending response is dropped, and no write is issued after the reset edge.
- memoryena, mem_addr and mem_din are registered. req_ready = (state==IDLE) && rst_n, combinational.
- State machine has four states: IDLE, WRITE, READ, RESP.
- IDLE: memoryena=00, which is a harmless block-1 read; mem_addr and mem_din hold their last values. On accept, latch bank=req_addr[ADDR_WIDTH-1] and mem_addr=req_addr[ADDR_WIDTH-2:0].
  - If req_write=1: mem_din=req_wdata, memoryena={bank,1}, go to WRITE.
  - If req_write=0: memoryena={bank,0}, cnt=READ_LATENCY, go to READ.
- WRITE: lasts exactly one cycle. Next edge: memoryena=00, go to IDLE. No response is generated for stores.
- READ: memoryena={bank,0} and mem_addr are held; cnt decrements each edge.
  - On the edge where cnt==0, capture resp_rdata from block2_dout if bank=1, else from block1_dout.
  - On that same edge set resp_valid=1, memoryena=00, go to RESP.
  - Result: resp_valid first rises READ_LATENCY+1 edges after the accept edge.
- RESP: resp_valid=1 and resp_rdata stable until an edge with resp_ready=1. On that edge resp_valid=0, go to IDLE.
- Throughput: at most one store every 2 cycles; one load every READ_LATENCY+3 cycles when resp_ready is tied high.
- Write-enable safety: the write bit of memoryena is 1 only during the single WRITE cycle, never in any other state and never in the cycle after reset.
- req_valid while req_ready=0 has no effect.
- req_valid=0 in IDLE keeps the block idle indefinitely.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req_valid=1 -> req_ready=0, memoryena=00, resp_valid=0, busy=0. Release -> req_ready=1 the same cycle.
- Store bank 0: req addr=0x005, wdata=0xDEADBEEF, write=1 -> exactly one cycle with memoryena=01, mem_addr=0x005, mem_din=0xDEADBEEF; then memoryena=00 and req_ready=1.
- Store/load bank 1, READ_LATENCY=2: store 0x805 / 0x12345678, then load 0x805 with the block-2 model returning 0x12345678 -> memoryena=11 for one cycle, then 10 for 3 cycles. resp_valid rises 3 edges after the load accept edge with resp_rdata=0x12345678; block1_dout value is ignored.
- Response backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid=1 and resp_rdata stable throughout, req_ready=0, busy=1. Raise resp_ready -> IDLE next edge.
- Reset mid-read: assert rst_n=0 while in READ -> memoryena=00 at that edge, resp_valid never asserts, and the next accepted request behaves normally.
- Back-to-back stores with req_valid held high (addrs 0x001, 0x802) -> accepts 2 cycles apart. memoryena sequence is 01,00,11,00; no write bit is set outside those cycles.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// Load/store front-end for the two-block data memory: splits the address into bank and word,
// drives the {bank, write} block-enable code and returns load data over a held handshake.
module mem_access_sequencer #(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [1:0]            memoryena,
    output logic [ADDR_WIDTH-2:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] block1_dout,
    input  logic [DATA_WIDTH-1:0] block2_dout,
    output logic                  busy
);

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("mem_access_sequencer: READ_LATENCY must be in 1..4");
    end

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StResp} state_e;

    state_e                state_q, state_d;
    logic [1:0]            ena_q, ena_d;
    logic [ADDR_WIDTH-2:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        state_d  = state_q;
        ena_d    = ena_q;
        addr_d   = addr_q;
        din_d    = din_q;
        cnt_d    = cnt_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        case (state_q)
            StIdle: begin
                ena_d = 2'b00;
                if (req_valid) begin
                    addr_d = req_addr[ADDR_WIDTH-2:0];
                    if (req_write) begin
                        din_d   = req_wdata;
                        ena_d   = {req_addr[ADDR_WIDTH-1], 1'b1};
                        state_d = StWrite;
                    end else begin
                        ena_d   = {req_addr[ADDR_WIDTH-1], 1'b0};
                        cnt_d   = 3'(READ_LATENCY);
                        state_d = StRead;
                    end
                end
            end
            StWrite: begin
                ena_d   = 2'b00;
                state_d = StIdle;
            end
            StRead: begin
                // ena_q[1] still carries the latched bank while the read is outstanding
                if (cnt_q == 3'd0) begin
                    rdata_d  = ena_q[1] ? block2_dout : block1_dout;
                    rvalid_d = 1'b1;
                    ena_d    = 2'b00;
                    state_d  = StResp;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    rvalid_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ena_q    <= 2'b00;
            addr_q   <= '0;
            din_q    <= '0;
            cnt_q    <= 3'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ena_q    <= ena_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign req_ready  = (state_q == StIdle) && rst_n;
    assign busy       = (state_q != StIdle);
    assign memoryena  = ena_q;
    assign mem_addr   = addr_q;
    assign mem_din    = din_q;
    assign resp_valid = rvalid_q;
    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Randomized bench for mem_access_sequencer: two block-RAM models with read latency and a
// transaction-level reference memory predicting every load result and enable code.
module tb_mem_access_sequencer;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] resp_rdata;
    logic [1:0]    memoryena;
    logic [AW-2:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] block1_dout;
    logic [DW-1:0] block2_dout;
    logic          busy;

    mem_access_sequencer #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .READ_LATENCY(RL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .memoryena  (memoryena),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .block1_dout(block1_dout),
        .block2_dout(block2_dout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int wr_cycles = 0;
    int exp_stores = 0;
    int last_wait = 0;
    logic [DW-1:0] ref_mem [int];

    function automatic logic [DW-1:0] init_word(input logic bank, input logic [3:0] word);
        return 32'hC0DE0000 | (32'(bank) << 8) | 32'(word);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Block RAM models: 16 words per bank, synchronous write, RL-stage read pipeline.
    logic [DW-1:0] blk [32];
    logic          blk_init = 1'b0;
    logic [DW-1:0] pipe1 [RL];
    logic [DW-1:0] pipe2 [RL];

    always @(posedge clk) begin
        if (!blk_init) begin
            for (int i = 0; i < 32; i++) blk[i] <= init_word(i[4], i[3:0]);
            blk_init <= 1'b1;
        end else if (memoryena[0] === 1'b1) begin
            blk[{memoryena[1], mem_addr[3:0]}] <= mem_din;
        end
        pipe1[0] <= blk[{1'b0, mem_addr[3:0]}];
        pipe2[0] <= blk[{1'b1, mem_addr[3:0]}];
        for (int i = 1; i < RL; i++) begin
            pipe1[i] <= pipe1[i-1];
            pipe2[i] <= pipe2[i-1];
        end
    end
    assign block1_dout = pipe1[RL-1];
    assign block2_dout = pipe2[RL-1];

    always @(negedge clk) if (memoryena[0] === 1'b1) wr_cycles++;

    task automatic do_req(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int hold);
        logic [DW-1:0] exp;
        int t;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        resp_ready = 1'b0;
        t = 0;
        while (!req_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        last_wait = t;
        check("ready_before_accept", req_ready, 1);
        @(posedge clk); #1;
        // scribble on the request bus while busy: must be ignored
        req_write = 1'($urandom); req_addr = AW'($urandom); req_wdata = $urandom;
        check("busy_after_accept", busy, 1);
        check("ena_after_accept", memoryena, {addr[AW-1], wr});
        check("mem_addr", mem_addr, addr[AW-2:0]);
        if (wr) begin
            check("mem_din", mem_din, wdata);
            ref_mem[int'(addr)] = wdata;
            exp_stores++;
            @(posedge clk); #1;
            check("ena_after_write", memoryena, 0);
            check("ready_after_write", req_ready, 1);
            check("resp_valid_store", resp_valid, 0);
        end else begin
            exp = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : init_word(addr[AW-1], addr[3:0]);
            for (int k = 0; k < RL; k++) begin
                @(posedge clk); #1;
                check("ena_read_hold", memoryena, {addr[AW-1], 1'b0});
                check("resp_early", resp_valid, 0);
                check("ready_in_read", req_ready, 0);
            end
            @(posedge clk); #1;
            check("resp_valid_rise", resp_valid, 1);
            check("resp_rdata", resp_rdata, exp);
            check("ena_in_resp", memoryena, 0);
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                check("resp_hold_valid", resp_valid, 1);
                check("resp_hold_rdata", resp_rdata, exp);
                check("resp_hold_ready", req_ready, 0);
                check("resp_hold_busy", busy, 1);
            end
            resp_ready = 1'b1;
            @(posedge clk); #1;
            check("resp_drop", resp_valid, 0);
            check("idle_after_resp", busy, 0);
            check("ready_after_resp", req_ready, 1);
            resp_ready = 1'b0;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset held with a pending store on the bus
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h005; req_wdata = 32'hDEADBEEF;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_ready", req_ready, 0);
            check("rst_ena", memoryena, 0);
            check("rst_resp_valid", resp_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_rdata", resp_rdata, 0);
        end
        rst_n = 1'b1;
        #1;
        check("ready_on_release", req_ready, 1);

        do_req(1'b1, 12'h005, 32'hDEADBEEF, 0);
        do_req(1'b1, 12'h805, 32'h12345678, 0);
        do_req(1'b0, 12'h805, 32'h0, 5);

        // Back-to-back stores with valid held high
        do_req(1'b1, 12'h001, 32'hA1A1A1A1, 0);
        do_req(1'b1, 12'h802, 32'hB2B2B2B2, 0);
        check("b2b_gap", last_wait, 0);
        do_req(1'b0, 12'h001, 32'h0, 0);
        do_req(1'b0, 12'h002, 32'h0, 1);

        // Reset in the middle of a read
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h803;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("midrd_ena_accept", memoryena, 2'b10);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrd_ena_reset", memoryena, 0);
        check("midrd_busy_reset", busy, 0);
        check("midrd_ready_reset", req_ready, 0);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            check("midrd_no_resp", resp_valid, 0);
            check("midrd_idle", busy, 0);
        end
        do_req(1'b0, 12'h803, 32'h0, 0);

        for (int n = 0; n < 150; n++) begin
            int idle;
            idle = $urandom_range(0, 2);
            for (int k = 0; k < idle; k++) begin
                @(posedge clk); #1;
                check("idle_busy", busy, 0);
                check("idle_ena", memoryena, 0);
            end
            do_req(1'($urandom), {1'($urandom), 7'b0, 4'($urandom)}, $urandom,
                   int'($urandom_range(0, 3)));
        end

        @(posedge clk); #1;
        check("write_cycle_count", wr_cycles, exp_stores);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
